spinner_wheel_core: RTL and testbench

- Parametrised next-generation spinner engine for the LED-spinner game.
- Drives an N-position wheel with a speed-selectable step rate and a selectable direction.
- On a stop request the wheel decelerates over a fixed number of steps instead of halting on the next tick, then compares the landing position against the player's guess mask.
- Keeps a saturating score. It sits between the pad-level input synchronisers and the LED/7-segment output decoders.

---
 rtl/spinner_wheel_core.sv | 151 +++++++++++++++
 tb/tb_spinner_wheel_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spinner_wheel_core.sv
// LED-spinner wheel engine: prescaled stepping, decelerating stop, guess compare
// and a saturating score.
module spinner_wheel_core #(
    parameter int N_LEDS      = 6,
    parameter int PRESC_W     = 24,
    parameter int BASE_LIMIT  = 6250000,
    parameter int DECEL_STEPS = 4,
    parameter int SCORE_W     = 8,
    localparam int POS_W      = $clog2(N_LEDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         speed,
    input  logic               dir,
    input  logic               stop_req,
    input  logic [N_LEDS-1:0]  guess,
    input  logic               clear_score,
    output logic [POS_W-1:0]   pos,
    output logic [N_LEDS-1:0]  pos_onehot,
    output logic               stopped,
    output logic               result_valid,
    output logic               hit,
    output logic [SCORE_W-1:0] score
);

    localparam int SLOW_W = $clog2(DECEL_STEPS + 1);
    localparam logic [PRESC_W-1:0] BASE_P    = PRESC_W'(BASE_LIMIT);
    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(N_LEDS - 1);
    localparam logic [SLOW_W-1:0]  SLOW_INIT = SLOW_W'(DECEL_STEPS);
    localparam logic [N_LEDS-1:0]  ONE_HOT0  = N_LEDS'(1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_SPIN    = 2'd1,
        ST_SLOW    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0]   period_q, period_d;
    logic [SLOW_W-1:0]    slow_q, slow_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [N_LEDS-1:0]    onehot_q, onehot_d;
    logic                 hit_q, hit_d;
    logic                 rv_q, rv_d;
    logic [SCORE_W-1:0]   score_q, score_d;

    logic [PRESC_W-1:0]   shifted;
    logic [PRESC_W-1:0]   speed_period;
    logic [PRESC_W-1:0]   dbl_period;
    logic [POS_W-1:0]     pos_step;
    logic                 tick;
    logic                 land;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_STOPPED;
            cnt_q    <= '0;
            period_q <= BASE_P;
            slow_q   <= '0;
            pos_q    <= '0;
            onehot_q <= ONE_HOT0;
            hit_q    <= 1'b0;
            rv_q     <= 1'b0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            slow_q   <= slow_d;
            pos_q    <= pos_d;
            onehot_q <= onehot_d;
            hit_q    <= hit_d;
            rv_q     <= rv_d;
            score_q  <= score_d;
        end
    end

    always_comb begin
        shifted      = BASE_P >> speed;
        speed_period = (shifted == '0) ? PRESC_W'(1) : shifted;
        // Doubling saturates at the all-ones period rather than wrapping.
        dbl_period   = period_q[PRESC_W-1] ? '1 : (period_q << 1);
        tick         = (state_q != ST_STOPPED) && (cnt_q == period_q - PRESC_W'(1));
        if (dir) pos_step = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
        else     pos_step = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);

        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + PRESC_W'(1);
        period_d = period_q;
        slow_d   = slow_q;
        pos_d    = pos_q;
        hit_d    = hit_q;
        rv_d     = 1'b0;
        score_d  = score_q;
        land     = 1'b0;

        case (state_q)
            ST_STOPPED: begin
                cnt_d = '0;
                if (!stop_req) begin
                    state_d  = ST_SPIN;
                    period_d = speed_period;
                    hit_d    = 1'b0;
                end
            end
            ST_SPIN: begin
                if (tick) begin
                    pos_d = pos_step;
                    if (stop_req) begin
                        state_d  = ST_SLOW;
                        slow_d   = SLOW_INIT;
                        period_d = dbl_period;
                    end else begin
                        period_d = speed_period;
                    end
                end
            end
            ST_SLOW: begin
                if (tick) begin
                    pos_d    = pos_step;
                    period_d = dbl_period;
                    slow_d   = slow_q - SLOW_W'(1);
                    if (slow_q == SLOW_W'(1)) begin
                        state_d = ST_STOPPED;
                        land    = 1'b1;
                    end
                end
            end
            default: state_d = ST_STOPPED;
        endcase

        onehot_d = ONE_HOT0 << pos_d;

        // Result is registered at the landing step so it appears on STOPPED entry.
        if (land) begin
            rv_d  = 1'b1;
            hit_d = |(guess & onehot_d);
            if (hit_d && (score_q != '1)) score_d = score_q + SCORE_W'(1);
        end
        if (clear_score) score_d = '0;
    end

    assign pos          = pos_q;
    assign pos_onehot   = onehot_q;
    assign stopped      = (state_q == ST_STOPPED);
    assign result_valid = rv_q;
    assign hit          = hit_q;
    assign score        = score_q;

endmodule

// File: tb/tb_spinner_wheel_core.sv
// Scoreboard bench for spinner_wheel_core: stimulus queues expected steps/results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_spinner_wheel_core;

    localparam int N  = 6;
    localparam int PW = 8;
    localparam int BL = 8;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] speed = 3'd0;
    logic       dir = 1'b0;
    logic       stop_req = 1'b1;
    logic [5:0] guess = 6'd0;
    logic       clear_score = 1'b0;

    logic [2:0] pos_a, pos_b;
    logic [5:0] oh_a, oh_b;
    logic       stopped_a, stopped_b, rv_a, rv_b, hit_a, hit_b;
    logic [7:0] score_a;
    logic [1:0] score_b;

    spinner_wheel_core #(.N_LEDS(N), .PRESC_W(PW), .BASE_LIMIT(BL), .DECEL_STEPS(DS), .SCORE_W(8)) dut_a (
        .clk(clk), .rst(rst), .speed(speed), .dir(dir), .stop_req(stop_req), .guess(guess),
        .clear_score(clear_score), .pos(pos_a), .pos_onehot(oh_a), .stopped(stopped_a),
        .result_valid(rv_a), .hit(hit_a), .score(score_a));

    spinner_wheel_core #(.N_LEDS(N), .PRESC_W(PW), .BASE_LIMIT(BL), .DECEL_STEPS(DS), .SCORE_W(2)) dut_b (
        .clk(clk), .rst(rst), .speed(speed), .dir(dir), .stop_req(stop_req), .guess(guess),
        .clear_score(clear_score), .pos(pos_b), .pos_onehot(oh_b), .stopped(stopped_b),
        .result_valid(rv_b), .hit(hit_b), .score(score_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int pos;
        int at;
        int hit;
        int sc;
        int sc2;
    } ev_t;

    ev_t step_q[$];
    ev_t res_q[$];

    int prev_pos = 0;
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst) begin
            prev_pos = int'(pos_a);
        end else begin
            if (int'(pos_a) != prev_pos) begin
                if (step_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_step: pos %0d at cycle %0d, expected no step", pos_a, cyc);
                end else begin
                    e = step_q.pop_front();
                    chk("step_pos", int'(pos_a), e.pos);
                    chk("step_cycle", cyc, e.at);
                    chk("step_onehot", int'(oh_a), 1 << e.pos);
                end
                prev_pos = int'(pos_a);
            end
            if (rv_a) begin
                if (res_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: result_valid at cycle %0d, expected none", cyc);
                end else begin
                    e = res_q.pop_front();
                    chk("res_cycle", cyc, e.at);
                    chk("res_pos", int'(pos_a), e.pos);
                    chk("res_hit", int'(hit_a), e.hit);
                    chk("res_score", int'(score_a), e.sc);
                    chk("res_score_sat2", int'(score_b), e.sc2);
                    chk("res_valid_b", int'(rv_b), 1);
                    chk("res_stopped", int'(stopped_a), 1);
                end
            end
        end
    end

    int m_pos = 0;
    bit m_dir = 1'b0;
    int e_sc  = 0;
    int e_sc2 = 0;

    function automatic int nxt(input int p, input bit d);
        if (d) return (p == 0) ? N - 1 : p - 1;
        return (p == N - 1) ? 0 : p + 1;
    endfunction

    task automatic push_step(input int at);
        m_pos = nxt(m_pos, m_dir);
        step_q.push_back('{m_pos, at, 0, 0, 0});
    endtask

    task automatic push_result(input int at, input logic [5:0] g, input bit clr);
        int h;
        h = int'(g[m_pos]);
        if (clr) begin
            e_sc  = 0;
            e_sc2 = 0;
        end else if (h != 0) begin
            if (e_sc < 255) e_sc++;
            if (e_sc2 < 3) e_sc2++;
        end
        res_q.push_back('{m_pos, at, h, e_sc, e_sc2});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One run: release, nsteps free steps (dir flips after step 'tog'), then stop.
    task automatic spin_run(input int spd, input bit d, input int nsteps, input int tog,
                            input logic [5:0] g, input bit clr);
        int c, p, t;
        c = cyc;
        p = BL >> spd;
        if (p < 1) p = 1;
        speed    = 3'(spd);
        dir      = d;
        m_dir    = d;
        guess    = g;
        stop_req = 1'b0;
        wait_until(c + 1);
        chk("spin_not_stopped", int'(stopped_a), 0);
        chk("spin_hit_cleared", int'(hit_a), 0);
        t = c + 1;
        for (int k = 1; k <= nsteps; k++) begin
            t = c + 1 + p * k;
            push_step(t);
            if (k == tog) begin
                wait_until(t);
                dir   = ~dir;
                m_dir = ~m_dir;
            end
        end
        wait_until(t);
        stop_req = 1'b1;
        for (int k = 0; k <= DS; k++) begin
            t = t + (p << k);
            push_step(t);
        end
        push_result(t, g, clr);
        if (clr) begin
            wait_until(t - 1);
            clear_score = 1'b1;
        end
        wait_until(t);
        clear_score = 1'b0;
        wait_until(t + 2);
        chk("rest_stopped", int'(stopped_a), 1);
        chk("rest_hit_held", int'(hit_a), int'(g[m_pos]));
        chk("rest_pos", int'(pos_a), m_pos);
        chk("rest_valid_low", int'(rv_a), 0);
    endtask

    initial begin : stim
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pos", int'(pos_a), 0);
        chk("rst_onehot", int'(oh_a), 1);
        chk("rst_stopped", int'(stopped_a), 1);
        chk("rst_valid", int'(rv_a), 0);
        chk("rst_hit", int'(hit_a), 0);
        chk("rst_score", int'(score_a), 0);
        rst = 1'b0;
        wait_until(cyc + 3);
        chk("idle_pos", int'(pos_a), 0);
        chk("idle_stopped", int'(stopped_a), 1);

        spin_run(0, 1'b0, 8, 0, 6'b000001, 1'b0);
        spin_run(2, 1'b0, 4, 0, 6'b000000, 1'b0);
        spin_run(7, 1'b1, 6, 4, 6'b010000, 1'b0);
        repeat (3) spin_run(7, 1'b0, 0, 0, 6'b111111, 1'b0);
        spin_run(7, 1'b0, 0, 0, 6'b111111, 1'b1);

        // Reset while decelerating: back to rest with no result.
        c        = cyc;
        speed    = 3'd0;
        dir      = 1'b0;
        m_dir    = 1'b0;
        guess    = 6'b111111;
        stop_req = 1'b0;
        wait_until(c + 1);
        stop_req = 1'b1;
        push_step(c + 9);
        wait_until(c + 12);
        rst = 1'b1;
        wait_until(c + 14);
        chk("slow_rst_pos", int'(pos_a), 0);
        chk("slow_rst_onehot", int'(oh_a), 1);
        chk("slow_rst_stopped", int'(stopped_a), 1);
        chk("slow_rst_valid", int'(rv_a), 0);
        chk("slow_rst_score", int'(score_a), 0);
        rst   = 1'b0;
        m_pos = 0;
        e_sc  = 0;
        e_sc2 = 0;
        wait_until(c + 250);
        chk("post_rst_pos", int'(pos_a), 0);
        chk("post_rst_stopped", int'(stopped_a), 1);

        chk("steps_left", step_q.size(), 0);
        chk("results_left", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
